dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port data memory between the processor memory stage and an auxiliary master (loader/debug/DMA). It sits between `my_processor` and the dmem inside `skeleton`. It resolves per-cycle contention with processor priority and a starvation guard, supports short locked auxiliary bursts, stalls the processor when it loses, and routes one-cycle-latency read data back to the owning requester.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the processor memory stage
// and an auxiliary master, with processor priority, a starvation guard and locked aux bursts.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int MAX_LOCK  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_wren,
    input  logic [11:0] p_addr,
    input  logic [31:0] p_data,
    output logic        p_stall,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    input  logic        a_req,
    input  logic        a_wren,
    input  logic [11:0] a_addr,
    input  logic [31:0] a_data,
    input  logic        a_lock,
    output logic        a_grant,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    localparam int SW = $clog2(MAX_BURST + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] P_OWN = 1'b0;
    localparam logic [0:0] A_OWN = 1'b1;

    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_nxt_s;
    logic [LW-1:0] lock_cnt_r;
    logic [LW-1:0] lock_nxt_s;
    logic          p_gnt_s;
    logic          a_gnt_s;
    logic          rd_valid_r;
    logic          rd_owner_r;

    // Per-cycle grant decision; nothing is granted while reset is asserted.
    always_comb begin
        p_gnt_s = 1'b0;
        a_gnt_s = 1'b0;
        if (!reset) begin
            p_gnt_s = 1'b0;
            a_gnt_s = 1'b0;
        end else begin
            case (state_r)
                P_OWN: begin
                    if (a_req && (starve_cnt_r == SW'(MAX_BURST))) begin
                        a_gnt_s = 1'b1;
                    end else if (p_req) begin
                        p_gnt_s = 1'b1;
                    end else if (a_req) begin
                        a_gnt_s = 1'b1;
                    end else begin
                        a_gnt_s = 1'b0;
                    end
                end
                A_OWN:   a_gnt_s = a_req;
                default: a_gnt_s = 1'b0;
            endcase
        end
    end

    // Next ownership state, starvation counter and lock counter.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_cnt_r;
        lock_nxt_s   = lock_cnt_r;
        if (!a_req || a_gnt_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if (p_gnt_s && (starve_cnt_r != SW'(MAX_BURST))) begin
            starve_nxt_s = starve_cnt_r + SW'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
        case (state_r)
            P_OWN: begin
                // A single-access lock limit means the entering grant already exhausts it.
                if (a_gnt_s && a_lock && (MAX_LOCK > 1)) begin
                    state_nxt_s = A_OWN;
                    lock_nxt_s  = LW'(1);
                end else begin
                    state_nxt_s = P_OWN;
                    lock_nxt_s  = {LW{1'b0}};
                end
            end
            A_OWN: begin
                if (!a_gnt_s || !a_lock || ((lock_cnt_r + LW'(1)) == LW'(MAX_LOCK))) begin
                    state_nxt_s = P_OWN;
                    lock_nxt_s  = {LW{1'b0}};
                end else begin
                    state_nxt_s = A_OWN;
                    lock_nxt_s  = lock_cnt_r + LW'(1);
                end
            end
            default: begin
                state_nxt_s = P_OWN;
                lock_nxt_s  = {LW{1'b0}};
            end
        endcase
    end

    // State registers and read-return tracking; reset discards any outstanding read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= P_OWN;
            starve_cnt_r <= {SW{1'b0}};
            lock_cnt_r   <= {LW{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_owner_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            lock_cnt_r   <= lock_nxt_s;
            rd_valid_r   <= (p_gnt_s & ~p_wren) | (a_gnt_s & ~a_wren);
            rd_owner_r   <= a_gnt_s;
        end
    end

    // Memory port mux driven by whichever requester holds the grant.
    always_comb begin
        if (a_gnt_s) begin
            address_dmem = a_addr;
            data         = a_data;
            wren         = a_wren;
        end else if (p_gnt_s) begin
            address_dmem = p_addr;
            data         = p_data;
            wren         = p_wren;
        end else begin
            address_dmem = 12'h000;
            data         = 32'h0000_0000;
            wren         = 1'b0;
        end
    end

    assign p_stall  = reset & p_req & ~p_gnt_s;
    assign a_grant  = a_gnt_s;
    assign p_rvalid = reset & rd_valid_r & ~rd_owner_r;
    assign a_rvalid = reset & rd_valid_r & rd_owner_r;
    assign p_rdata  = q_dmem;
    assign a_rdata  = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus protocol-respecting
// random traffic compared against a rule-level model with a shadow memory.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;
    localparam int MAX_LOCK  = 8;

    logic        clock;
    logic        reset;
    logic        p_req, p_wren, p_stall, p_rvalid;
    logic [11:0] p_addr;
    logic [31:0] p_data, p_rdata;
    logic        a_req, a_wren, a_lock, a_grant, a_rvalid;
    logic [11:0] a_addr;
    logic [31:0] a_data, a_rdata;
    logic [11:0] address_dmem;
    logic [31:0] data, q_dmem;
    logic        wren;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem    [0:4095];
    logic [31:0] ref_mem [0:4095];

    // Model state
    bit          m_aown;
    int          m_starve;
    int          m_lock;
    bit          m_rdv, m_rdo;
    logic [31:0] m_rdd;
    // Model expectations for the current cycle
    bit          e_pg, e_ag, e_stall, e_wren, e_prv, e_arv;
    logic [11:0] e_addr;
    logic [31:0] e_data;

    dmem_arbiter #(.MAX_BURST(MAX_BURST), .MAX_LOCK(MAX_LOCK)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock),
        .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (wren) dmem[address_dmem] <= data;
        q_dmem <= dmem[address_dmem];
    end

    task automatic model_eval();
        e_pg = 1'b0;
        e_ag = 1'b0;
        if (reset) begin
            if (m_aown) e_ag = a_req;
            else if (a_req && m_starve >= MAX_BURST) e_ag = 1'b1;
            else if (p_req) e_pg = 1'b1;
            else if (a_req) e_ag = 1'b1;
        end
        e_stall = reset && p_req && !e_pg;
        e_wren  = e_ag ? a_wren : (e_pg ? p_wren : 1'b0);
        e_addr  = e_ag ? a_addr : (e_pg ? p_addr : 12'h000);
        e_data  = e_ag ? a_data : (e_pg ? p_data : 32'h0);
        e_prv   = reset && m_rdv && !m_rdo;
        e_arv   = reset && m_rdv && m_rdo;
    endtask

    task automatic model_update();
        if (!reset) begin
            m_aown = 1'b0; m_starve = 0; m_lock = 0; m_rdv = 1'b0; m_rdo = 1'b0;
        end else begin
            if (!a_req || e_ag) m_starve = 0;
            else if (e_pg && m_starve < MAX_BURST) m_starve = m_starve + 1;
            if (e_ag) begin
                if (!m_aown) begin
                    if (a_lock) begin m_aown = 1'b1; m_lock = 1; end
                end else begin
                    m_lock = m_lock + 1;
                end
                if (m_aown && (!a_lock || m_lock == MAX_LOCK)) begin m_aown = 1'b0; m_lock = 0; end
            end else if (m_aown) begin
                m_aown = 1'b0; m_lock = 0;
            end
            m_rdv = (e_pg || e_ag) && !e_wren;
            m_rdo = e_ag;
            if (e_pg || e_ag) begin
                m_rdd = ref_mem[e_addr];
                if (e_wren) ref_mem[e_addr] = e_data;
            end
        end
    endtask

    // One clock: model decides on current inputs, DUT and model advance on the edge.
    task automatic step();
        model_eval();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        p_req = 1'b0; a_req = 1'b0; a_lock = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0; p_req = 1'b1; a_req = 1'b1; p_wren = 1'b0; a_wren = 1'b0; a_lock = 1'b1;
        p_addr = 12'h055; a_addr = 12'h066; p_data = 32'h0; a_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({p_stall, a_grant, wren, p_rvalid, a_rvalid} !== 5'b00000 || address_dmem !== 12'h000 || data !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs: got stall/grant/wren/prv/arv=%b%b%b%b%b addr=%h data=%h expected all zero",
                         p_stall, a_grant, wren, p_rvalid, a_rvalid, address_dmem, data);
            end
            step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({p_stall, a_grant} !== 2'b00 || address_dmem !== 12'h055) begin
            failures++;
            $display("FAIL reset_release_grant: got stall=%b grant=%b addr=%h expected 0 0 055", p_stall, a_grant, address_dmem);
        end
        step();
        idle(2);
    endtask

    task automatic test_proc_only();
        p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h010; p_data = 32'h0000_0005; a_req = 1'b0;
        #1;
        checks++;
        if ({p_stall, wren} !== 2'b01 || address_dmem !== 12'h010 || data !== 32'h5) begin
            failures++;
            $display("FAIL proc_store: got stall=%b wren=%b addr=%h data=%h expected 0 1 010 00000005", p_stall, wren, address_dmem, data);
        end
        step();
        p_wren = 1'b0;
        #1;
        checks++;
        if ({p_stall, wren, p_rvalid} !== 3'b000 || address_dmem !== 12'h010) begin
            failures++;
            $display("FAIL proc_load: got stall=%b wren=%b prv=%b addr=%h expected 0 0 0 010", p_stall, wren, p_rvalid, address_dmem);
        end
        step();
        p_req = 1'b0;
        #1;
        checks++;
        if (p_rvalid !== 1'b1 || a_rvalid !== 1'b0 || p_rdata !== 32'h0000_0005) begin
            failures++;
            $display("FAIL proc_read_return: got prv=%b arv=%b rdata=%h expected 1 0 00000005", p_rvalid, a_rvalid, p_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        idle(1);
        for (int i = 0; i < 10; i++) begin
            p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h200 + 12'(i); p_data = 32'(i);
            a_req = 1'b1; a_wren = 1'b1; a_lock = 1'b0; a_addr = 12'h300; a_data = 32'hA5;
            #1;
            checks++;
            if ({a_grant, p_stall} !== {2{(i % 5) == 4}}) begin
                failures++;
                $display("FAIL contention_cycle%0d: got grant=%b stall=%b expected %b %b",
                         i, a_grant, p_stall, (i % 5) == 4, (i % 5) == 4);
            end
            step();
        end
        idle(1);
    endtask

    task automatic test_locked_burst();
        logic [2:0] locks;
        locks = 3'b011;
        for (int i = 0; i < 4; i++) begin
            p_req = (i != 0); p_wren = 1'b1; p_addr = 12'h040; p_data = 32'h77;
            a_req = 1'b1; a_wren = 1'b1; a_addr = 12'h100 + 12'(i); a_data = 32'hB0 + 32'(i);
            a_lock = (i < 3) ? locks[i] : 1'b0;
            #1;
            checks++;
            if ({a_grant, p_stall} !== ((i < 3) ? {1'b1, p_req} : 2'b00) || address_dmem !== ((i < 3) ? a_addr : p_addr)) begin
                failures++;
                $display("FAIL locked_burst_cycle%0d: got grant=%b stall=%b addr=%h", i, a_grant, p_stall, address_dmem);
            end
            step();
        end
        idle(1);
    endtask

    task automatic test_lock_timeout();
        for (int i = 0; i < 10; i++) begin
            p_req = (i != 0); p_wren = 1'b1; p_addr = 12'h050; p_data = 32'h1;
            a_req = 1'b1; a_wren = 1'b1; a_lock = 1'b1; a_addr = 12'h400 + 12'(i); a_data = 32'h2;
            #1;
            checks++;
            if (a_grant !== (i < 8) || p_stall !== (p_req && i < 8)) begin
                failures++;
                $display("FAIL lock_timeout_cycle%0d: got grant=%b stall=%b expected %b %b", i, a_grant, p_stall, i < 8, p_req && i < 8);
            end
            step();
        end
        idle(1);
    endtask

    task automatic test_reset_mid_read();
        a_req = 1'b1; a_wren = 1'b0; a_lock = 1'b0; a_addr = 12'h020; p_req = 1'b0;
        #1;
        checks++;
        if (a_grant !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_grant: got %b expected 1", a_grant);
        end
        reset = 1'b0;
        step();
        reset = 1'b1; a_req = 1'b0;
        #1;
        checks++;
        if ({a_rvalid, p_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL mid_read_discard: got arv=%b prv=%b expected 0 0", a_rvalid, p_rvalid);
        end
        step();
    endtask

    task automatic test_random();
        bit p_hold, a_hold;
        p_hold = 1'b0; a_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            if (!p_hold) begin
                p_req = ($urandom_range(0, 9) < 6); p_wren = $urandom_range(0, 1);
                p_addr = 12'($urandom_range(0, 15)); p_data = $urandom;
            end
            if (!a_hold) begin
                a_req = ($urandom_range(0, 9) < 6); a_wren = $urandom_range(0, 1);
                a_lock = ($urandom_range(0, 3) != 0);
                a_addr = 12'($urandom_range(0, 15)); a_data = $urandom;
            end
            #1;
            model_eval();
            checks++;
            if ({p_stall, a_grant, wren, address_dmem, data} !== {e_stall, e_ag, e_wren, e_addr, e_data}) begin
                failures++;
                $display("FAIL rand_port_%0d: got stall=%b grant=%b wren=%b addr=%h data=%h expected %b %b %b %h %h",
                         i, p_stall, a_grant, wren, address_dmem, data, e_stall, e_ag, e_wren, e_addr, e_data);
            end
            checks++;
            if ({p_rvalid, a_rvalid} !== {e_prv, e_arv}) begin
                failures++;
                $display("FAIL rand_rvalid_%0d: got prv=%b arv=%b expected %b %b", i, p_rvalid, a_rvalid, e_prv, e_arv);
            end
            if (e_prv || e_arv) begin
                checks++;
                if ((e_prv ? p_rdata : a_rdata) !== m_rdd) begin
                    failures++;
                    $display("FAIL rand_rdata_%0d: got p=%h a=%h expected %h", i, p_rdata, a_rdata, m_rdd);
                end
            end
            p_hold = p_req && !e_pg;
            a_hold = a_req && !e_ag;
            step();
        end
        reset = 1'b1;
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            dmem[i]    = 32'(i) * 32'h9E37_79B1;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        m_aown = 1'b0; m_starve = 0; m_lock = 0; m_rdv = 1'b0; m_rdo = 1'b0; m_rdd = 32'h0;
        reset = 1'b0; p_req = 1'b0; a_req = 1'b0; p_wren = 1'b0; a_wren = 1'b0; a_lock = 1'b0;
        p_addr = 12'h000; a_addr = 12'h000; p_data = 32'h0; a_data = 32'h0;
        @(negedge clock);
        test_reset();
        test_proc_only();
        test_contention();
        test_locked_burst();
        test_lock_timeout();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
